// File: rtl/dispatch_rst.sv
// Dispatch stage with a register status table for RAW/WAW tracking.
// Holds one branch in flight and flushes fetch on a mispredict.
module dispatch_rst #(
    parameter int NREGS = 32,
    parameter int NFU = 5,
    localparam int RW = $clog2(NREGS),
    localparam int FUW = $clog2(NFU),
    localparam int TAGW = $clog2(NFU + 1)
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [RW-1:0]   in_rd,
    input  logic [FUW-1:0]  in_fu,
    input  logic            in_wen,
    input  logic            in_branch,
    input  logic [NFU-1:0]  fu_busy,
    input  logic            wb_valid,
    input  logic [RW-1:0]   wb_rd,
    input  logic [FUW-1:0]  wb_fu,
    input  logic            branch_resolved,
    input  logic            branch_miss,
    output logic            out_valid,
    output logic [FUW-1:0]  out_fu,
    output logic [RW-1:0]   out_rd,
    output logic            out_wen,
    output logic [TAGW-1:0] out_t1,
    output logic [TAGW-1:0] out_t2,
    output logic            freeze,
    output logic            jump
);

    typedef enum logic [1:0] {RUN, WAIT_BR, FLUSH} state_t;

    state_t state;
    state_t state_nxt;

    logic [TAGW-1:0] tbl [NREGS];

    logic            busy;
    logic            waw;
    logic            accept;
    logic            wb_clr;
    logic [TAGW-1:0] set_tag;
    logic [TAGW-1:0] wb_tag;
    logic [TAGW-1:0] t1;
    logic [TAGW-1:0] t2;

    // FU busy lookup; an index beyond the last FU reads as busy
    always_comb begin
        busy = 1'b1;
        for (int i = 0; i < NFU; i++) begin
            if (in_fu == FUW'(i)) busy = fu_busy[i];
        end
    end

    assign set_tag = TAGW'(in_fu) + TAGW'(1);
    assign wb_tag  = TAGW'(wb_fu) + TAGW'(1);
    assign waw     = in_wen && (in_rd != '0) && (tbl[in_rd] != '0);
    assign wb_clr  = wb_valid && (wb_rd != '0) && (tbl[wb_rd] == wb_tag);
    assign accept  = in_valid && in_ready;
    assign freeze  = in_valid && !in_ready;

    // Operand tags, with writeback bypass for the entry cleared this cycle
    always_comb begin
        t1 = tbl[in_rs1];
        t2 = tbl[in_rs2];
        if (in_rs1 == '0 || (wb_clr && wb_rd == in_rs1)) t1 = '0;
        if (in_rs2 == '0 || (wb_clr && wb_rd == in_rs2)) t2 = '0;
    end

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= state_nxt;
    end

    // Next-state logic for the single outstanding branch
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (accept && in_branch) state_nxt = WAIT_BR;
            end
            WAIT_BR: begin
                if (branch_resolved)
                    state_nxt = branch_miss ? FLUSH : RUN;
            end
            FLUSH:   state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Handshake and redirect outputs decoded from state
    always_comb begin
        in_ready = (state == RUN) && !busy && !waw;
        jump     = (state == FLUSH);
    end

    // Status table: a new producer overrides a same-cycle clear
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) tbl[i] <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (accept && in_wen && in_rd == RW'(i))
                    tbl[i] <= set_tag;
                else if (wb_clr && wb_rd == RW'(i))
                    tbl[i] <= '0;
            end
        end
    end

    // Registered dispatch bundle towards issue
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid <= 1'b0;
            out_fu    <= '0;
            out_rd    <= '0;
            out_wen   <= 1'b0;
            out_t1    <= '0;
            out_t2    <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_fu  <= in_fu;
                out_rd  <= in_rd;
                out_wen <= in_wen;
                out_t1  <= t1;
                out_t2  <= t2;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_rst.sv
// Bench for dispatch_rst: vector table with a scoreboard of
// expected dispatch bundles, plus branch and reset sequences.
module tb_dispatch_rst;

    logic       CLK;
    logic       nRST;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] in_rs1;
    logic [4:0] in_rs2;
    logic [4:0] in_rd;
    logic [2:0] in_fu;
    logic       in_wen;
    logic       in_branch;
    logic [4:0] fu_busy;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic [2:0] wb_fu;
    logic       branch_resolved;
    logic       branch_miss;
    logic       out_valid;
    logic [2:0] out_fu;
    logic [4:0] out_rd;
    logic       out_wen;
    logic [2:0] out_t1;
    logic [2:0] out_t2;
    logic       freeze;
    logic       jump;

    dispatch_rst dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_fu(in_fu), .in_wen(in_wen), .in_branch(in_branch),
        .fu_busy(fu_busy),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_fu(wb_fu),
        .branch_resolved(branch_resolved), .branch_miss(branch_miss),
        .out_valid(out_valid), .out_fu(out_fu), .out_rd(out_rd),
        .out_wen(out_wen), .out_t1(out_t1), .out_t2(out_t2),
        .freeze(freeze), .jump(jump)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic [2:0] fu;
        logic       wen;
        logic [4:0] busy;
        logic       wbv;
        logic [4:0] wbrd;
        logic [2:0] wbfu;
        logic       rdy;
        logic [2:0] t1, t2;
    } vec_t;

    typedef struct {
        logic [2:0] fu;
        logic [4:0] rd;
        logic       wen;
        logic [2:0] t1, t2;
    } out_t;

    vec_t tv[$];
    out_t sb[$];
    int   nvec = 0;
    int   nmis = 0;

    function automatic vec_t mk(
        input logic v, input int rs1, input int rs2, input int rd,
        input int fu, input logic wen, input int busy,
        input logic wbv, input int wbrd, input int wbfu,
        input logic rdy, input int t1, input int t2);
        vec_t x;
        x.v = v; x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.rd = 5'(rd);
        x.fu = 3'(fu); x.wen = wen; x.busy = 5'(busy);
        x.wbv = wbv; x.wbrd = 5'(wbrd); x.wbfu = 3'(wbfu);
        x.rdy = rdy; x.t1 = 3'(t1); x.t2 = 3'(t2);
        return x;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int fu, input int rd, input logic wen,
                        input int t1, input int t2);
        out_t o;
        o.fu = 3'(fu); o.rd = 5'(rd); o.wen = wen;
        o.t1 = 3'(t1); o.t2 = 3'(t2);
        sb.push_back(o);
    endtask

    task automatic edge_out(input string nm);
        out_t o;
        @(posedge CLK);
        #1;
        if (sb.size() > 0) begin
            o = sb.pop_front();
            chk({nm, ".out_valid"}, int'(out_valid), 1);
            chk({nm, ".out_fu"}, int'(out_fu), int'(o.fu));
            chk({nm, ".out_rd"}, int'(out_rd), int'(o.rd));
            chk({nm, ".out_wen"}, int'(out_wen), int'(o.wen));
            chk({nm, ".out_t1"}, int'(out_t1), int'(o.t1));
            chk({nm, ".out_t2"}, int'(out_t2), int'(o.t2));
        end else begin
            chk({nm, ".out_valid"}, int'(out_valid), 0);
        end
    endtask

    task automatic put(input logic v, input int rs1, input int rs2,
                       input int rd, input int fu, input logic wen,
                       input logic br);
        in_valid = v; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
        in_rd = 5'(rd); in_fu = 3'(fu); in_wen = wen;
        in_branch = br; fu_busy = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_fu = '0;
    endtask

    initial begin
        nRST = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0);
        branch_resolved = 1'b0;
        branch_miss = 1'b0;

        // idle / REQ-036..043 style table
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 5, 2, 1, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
        tv.push_back(mk(1, 5, 5, 0, 1, 0, 0, 1, 5, 2, 1, 0, 0));
        tv.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 7, 0, 1, 0, 1, 7, 1, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 7, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 7, 0, 4, 0, 0, 1, 7, 3, 1, 0, 1));
        tv.push_back(mk(1, 7, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0));
        tv.push_back(mk(1, 0, 0, 0, 3, 0, 8, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 3, 0, 8, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 0, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0));
        tv.push_back(mk(1, 0, 7, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0));
        tv.push_back(mk(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

        repeat (2) @(posedge CLK);
        #1;
        chk("rst.out_valid", int'(out_valid), 0);
        chk("rst.out_rd", int'(out_rd), 0);
        chk("rst.out_t1", int'(out_t1), 0);
        chk("rst.jump", int'(jump), 0);
        nRST = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            vec_t x;
            x = tv[i];
            in_valid = x.v; in_rs1 = x.rs1; in_rs2 = x.rs2;
            in_rd = x.rd; in_fu = x.fu; in_wen = x.wen;
            in_branch = 1'b0; fu_busy = x.busy;
            wb_valid = x.wbv; wb_rd = x.wbrd; wb_fu = x.wbfu;
            #1;
            chk($sformatf("v%0d.in_ready", i), int'(in_ready), int'(x.rdy));
            chk($sformatf("v%0d.freeze", i), int'(freeze),
                int'(x.v && !x.rdy));
            if (x.v && x.rdy) push(x.fu, x.rd, x.wen, x.t1, x.t2);
            edge_out($sformatf("v%0d", i));
        end

        // mispredicted branch: block, flush pulse, resume
        put(1, 0, 0, 0, 0, 0, 1);
        #1; chk("brm.ready0", int'(in_ready), 1);
        push(0, 0, 0, 0, 0);
        edge_out("brm.br");
        put(1, 0, 0, 3, 1, 1, 0);
        #1; chk("brm.blocked", int'(in_ready), 0);
        chk("brm.freeze", int'(freeze), 1);
        edge_out("brm.wait");
        branch_resolved = 1'b1; branch_miss = 1'b1;
        #1; chk("brm.res_ready", int'(in_ready), 0);
        chk("brm.res_jump", int'(jump), 0);
        edge_out("brm.res");
        branch_resolved = 1'b0; branch_miss = 1'b0;
        #1; chk("brm.jump", int'(jump), 1);
        chk("brm.flush_ready", int'(in_ready), 0);
        edge_out("brm.flush");
        #1; chk("brm.jump_off", int'(jump), 0);
        chk("brm.resume", int'(in_ready), 1);
        push(1, 3, 1, 0, 0);
        edge_out("brm.acc");
        put(1, 3, 0, 0, 2, 0, 0);
        #1; push(2, 0, 0, 2, 0);
        edge_out("brm.dep");
        put(1, 0, 0, 0, 0, 0, 0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_fu = 3'd1;
        #1; push(0, 0, 0, 0, 0);
        edge_out("brm.wb");

        // correctly predicted branch resumes without a flush
        put(1, 0, 0, 0, 2, 0, 1);
        #1; chk("brh.ready", int'(in_ready), 1);
        push(2, 0, 0, 0, 0);
        edge_out("brh.br");
        put(1, 0, 0, 0, 1, 0, 0);
        branch_resolved = 1'b1; branch_miss = 1'b0;
        #1; chk("brh.blocked", int'(in_ready), 0);
        edge_out("brh.res");
        branch_resolved = 1'b0;
        #1; chk("brh.jump", int'(jump), 0);
        chk("brh.resume", int'(in_ready), 1);
        push(1, 0, 0, 0, 0);
        edge_out("brh.acc");

        // resolve while running is ignored
        put(0, 0, 0, 0, 0, 0, 0);
        branch_resolved = 1'b1; branch_miss = 1'b1;
        #1; edge_out("run.res");
        branch_resolved = 1'b0; branch_miss = 1'b0;
        #1; chk("run.jump", int'(jump), 0);
        chk("run.ready", int'(in_ready), 1);

        // reset while waiting on a branch
        put(1, 0, 0, 9, 1, 1, 1);
        #1; chk("rw.ready", int'(in_ready), 1);
        push(1, 9, 1, 0, 0);
        edge_out("rw.br");
        put(1, 9, 0, 0, 0, 0, 0);
        #1; chk("rw.blocked", int'(in_ready), 0);
        nRST = 1'b0;
        #1;
        chk("rw.out_valid", int'(out_valid), 0);
        chk("rw.out_fu", int'(out_fu), 0);
        chk("rw.out_rd", int'(out_rd), 0);
        chk("rw.out_wen", int'(out_wen), 0);
        chk("rw.out_t1", int'(out_t1), 0);
        chk("rw.out_t2", int'(out_t2), 0);
        chk("rw.jump", int'(jump), 0);
        #1;
        nRST = 1'b1;
        #1; chk("rw.first_ready", int'(in_ready), 1);
        push(0, 0, 0, 0, 0);
        edge_out("rw.first");
        put(0, 0, 0, 0, 0, 0, 0);
        edge_out("rw.idle");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/dispatch_rst.md
DISPATCH_RST -- requirements
Module: dispatch_rst

Interface
REQ-001 Parameter NREGS, default 32: architectural register count; register 0 is never tracked.
REQ-002 Parameter NFU, default 5: number of functional units; FUW = $clog2(NFU); TAGW = $clog2(NFU+1).
REQ-003 Port CLK  input  1: the single clock, rising edge.
REQ-004 Port nRST  input  1: reset, asynchronous, active-low.
REQ-005 Ports in_valid input 1, in_ready output 1: instruction handshake from fetch.
REQ-006 Ports in_rs1, in_rs2, in_rd input $clog2(NREGS) each: source and destination registers.
REQ-007 Ports in_fu input FUW, in_wen input 1, in_branch input 1: target FU, writes rd, is a branch.
REQ-008 Port fu_busy  input  NFU: per-FU structural-busy flags from issue.
REQ-009 Ports wb_valid input 1, wb_rd input $clog2(NREGS), wb_fu input FUW: writeback completion.
REQ-010 Ports branch_resolved input 1, branch_miss input 1: from execute; miss is valid only with resolved.
REQ-011 Ports out_valid output 1, out_fu output FUW, out_rd output $clog2(NREGS), out_wen output 1: registered dispatch to issue.
REQ-012 Ports out_t1, out_t2 output TAGW each: producer tag of rs1/rs2; 0 = operand ready, k = FU k-1 pending.
REQ-013 Ports freeze output 1, jump output 1: stall to fetch; one-cycle redirect pulse.

Function
REQ-014 Internal register status table rst[1..NREGS-1], TAGW bits each, holds the producer tag per register.
REQ-015 State machine: RUN, WAIT_BR, FLUSH.
REQ-016 in_ready = state==RUN and !fu_busy[in_fu] and !(in_wen and in_rd!=0 and rst[in_rd]!=0); the last term is the WAW block.
REQ-017 freeze = in_valid and !in_ready, combinational.
REQ-018 Accept = in_valid and in_ready; accepted instruction appears on out_* exactly one cycle later, with out_valid high for exactly that one cycle.
REQ-019 out_valid is 0 in every cycle following a non-accept cycle.
REQ-020 out_t1 = 0 when rs1==0; otherwise it is rst[rs1] sampled at accept, with one exception.
REQ-021 Exception to REQ-020: it is 0 if same-cycle writeback clears that entry (WB bypass); out_t2 follows the same rule for rs2.
REQ-022 Accept with in_wen and in_rd!=0 sets rst[in_rd] <= in_fu+1.
REQ-023 wb_valid clears rst[wb_rd] only when rst[wb_rd]==wb_fu+1; stale writebacks are ignored.
REQ-024 Same-cycle accept setting and writeback clearing the same rd: the set wins.
REQ-025 Transition RUN->WAIT_BR: on accept with in_branch.
REQ-026 Transition WAIT_BR->RUN: on branch_resolved and !branch_miss.
REQ-027 Transition WAIT_BR->FLUSH: on branch_resolved and branch_miss.
REQ-028 Transition FLUSH->RUN: unconditionally after one cycle.
REQ-029 jump = 1 only in FLUSH; in FLUSH, in_valid is discarded without accept and out_valid is 0.
REQ-030 branch_resolved while in RUN is ignored.
REQ-031 Writebacks are processed in every state, including WAIT_BR and FLUSH.
REQ-032 Tags and FU indices never wrap: in_fu >= NFU is treated as not-ready (in_ready=0).

Reset
REQ-033 While nRST=0: state=RUN, all rst entries 0, out_valid=0, out_fu=0, out_rd=0, out_wen=0, out_t1=0, out_t2=0, jump=0.
REQ-034 Reset asserted mid-operation aborts any pending dispatch or branch wait immediately.
REQ-035 First accept is possible in the first cycle after nRST deasserts.

Verification
REQ-036 Reset, then send rd=5, fu=2, wen -> next cycle out_valid=1, out_rd=5, out_t1=0; rst[5]=3.
REQ-037 Follow with rs1=5, fu=0 -> out_t1=3.
REQ-038 Same cycle as REQ-037 scenario, add wb_valid with rd=5, fu=2 -> out_t1=0, rst[5]=0.
REQ-039 With rst[7]=2, send wen rd=7 -> in_ready=0, freeze=1; then wb rd=7, fu=1 -> accepted next cycle.
REQ-040 Set fu_busy[3]=1, send fu=3 -> freeze=1 and no out_valid until fu_busy[3]=0.
REQ-041 Dispatch a branch, then present an instruction -> blocked.
REQ-042 Continue REQ-041 with branch_resolved=1, branch_miss=1 -> jump=1 for one cycle, then accept resumes.
REQ-043 Wb with wb_fu mismatching the entry -> entry unchanged.
REQ-044 Pulse nRST=0 in WAIT_BR -> all outputs per REQ-033, state RUN.
